// File: rtl/multdiv_pkg.sv
// Shared types and constants for the X-stage multiply/divide unit.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0] MUL_OP_DEFAULT = 5'b00110;
  localparam logic [4:0] DIV_OP_DEFAULT = 5'b00111;
  localparam logic [4:0] OPCODE_RTYPE   = 5'b00000;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 27;
  localparam int RD_HI     = 26;
  localparam int RD_LO     = 22;
  localparam int ALUOP_HI  = 6;
  localparam int ALUOP_LO  = 2;

endpackage

// File: rtl/multdiv_datapath.sv
// Unsigned radix-2 iteration engine: shift-add multiply or restoring divide.
// {hi,lo} holds the running product; for divide hi is the remainder and lo the quotient.
module multdiv_datapath #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               op_div,
  input  logic [WIDTH-1:0]   load_lo,
  input  logic [WIDTH-1:0]   load_b,
  output logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   quot
);

  logic [WIDTH-1:0] hi, lo, b_q;
  logic [WIDTH:0]   sum, add_vec, rem_sh, diff;
  logic             fits;
  logic             unused_diff_msb;

  always_comb begin
    sum     = {1'b0, hi} + {1'b0, b_q};
    add_vec = lo[0] ? sum : {1'b0, hi};
    rem_sh  = {hi, lo[WIDTH-1]};
    diff    = rem_sh - {1'b0, b_q};
    fits    = (rem_sh >= {1'b0, b_q});
  end

  // remainder stays below the divisor, so the top bit of diff is always zero when kept
  assign unused_diff_msb = diff[WIDTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi  <= '0;
      lo  <= '0;
      b_q <= '0;
    end else if (load) begin
      hi  <= '0;
      lo  <= load_lo;
      b_q <= load_b;
    end else if (step) begin
      if (op_div) begin
        hi <= fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        lo <= {lo[WIDTH-2:0], fits};
      end else begin
        hi <= add_vec[WIDTH:1];
        lo <= {add_vec[0], lo[WIDTH-1:1]};
      end
    end
  end

  assign prod = {hi, lo};
  assign quot = lo;

endmodule

// File: rtl/x_multdiv_unit.sv
// Multi-cycle signed multiply/divide in the execute stage; stalls upstream while busy.
// Optional build macro MULTDIV_ZERO_SKIP_EN: zero-operand operations finish in one cycle.
module x_multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int         WIDTH  = 32,
  parameter logic [4:0] MUL_OP = MUL_OP_DEFAULT,
  parameter logic [4:0] DIV_OP = DIV_OP_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic [31:0]      in_ir,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             stall,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       result_rd,
  output logic             exception
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic             neg_q, op_div_q, exc_force_q;
  logic [4:0]       rd_q;
  logic [WIDTH-1:0] result_q;

  logic [4:0]         opcode, alu_op;
  logic               is_mul, is_div, start, div_zero, fast_zero, skip;
  logic [WIDTH-1:0]   abs_a, abs_b, load_lo, load_b;
  logic [2*WIDTH-1:0] prod, prod_signed;
  logic [WIDTH-1:0]   quot, quot_signed, final_res;
  logic               mul_ovf, final_exc, in_done;
  logic               unused_ir;

  assign opcode    = in_ir[OPCODE_HI:OPCODE_LO];
  assign alu_op    = in_ir[ALUOP_HI:ALUOP_LO];
  assign unused_ir = ^{in_ir[RD_LO-1:ALUOP_HI+1], in_ir[ALUOP_LO-1:0]};

  assign is_mul   = (opcode == OPCODE_RTYPE) && (alu_op == MUL_OP);
  assign is_div   = (opcode == OPCODE_RTYPE) && (alu_op == DIV_OP);
  assign start    = (state == IDLE) && !flush && (is_mul || is_div);
  assign div_zero = is_div && (in_b == '0);

`ifdef MULTDIV_ZERO_SKIP_EN
  assign fast_zero = (is_mul && ((in_a == '0) || (in_b == '0))) ||
                     (is_div && (in_a == '0) && (in_b != '0));
`else
  assign fast_zero = 1'b0;
`endif

  assign skip  = div_zero || fast_zero;
  assign abs_a = in_a[WIDTH-1] ? -in_a : in_a;
  assign abs_b = in_b[WIDTH-1] ? -in_b : in_b;

  // skipped operations load zeros so the DONE fix-up naturally yields 0
  always_comb begin
    load_lo = '0;
    load_b  = '0;
    if (!skip) begin
      load_lo = is_div ? abs_a : abs_b;
      load_b  = is_div ? abs_b : abs_a;
    end
  end

  multdiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clock   (clock),
    .reset   (reset),
    .load    (start),
    .step    (state == BUSY),
    .op_div  (op_div_q),
    .load_lo (load_lo),
    .load_b  (load_b),
    .prod    (prod),
    .quot    (quot)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = skip ? DONE : BUSY;
      BUSY:    if (count == CW'(WIDTH - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_comb begin
    prod_signed = neg_q ? -prod : prod;
    quot_signed = neg_q ? -quot : quot;
    mul_ovf     = !((&prod_signed[2*WIDTH-1:WIDTH-1]) || !(|prod_signed[2*WIDTH-1:WIDTH-1]));
    final_res   = op_div_q ? quot_signed : prod_signed[WIDTH-1:0];
    final_exc   = exc_force_q || (!op_div_q && mul_ovf);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      neg_q       <= 1'b0;
      op_div_q    <= 1'b0;
      exc_force_q <= 1'b0;
      rd_q        <= '0;
      result_q    <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        count       <= '0;
        neg_q       <= in_a[WIDTH-1] ^ in_b[WIDTH-1];
        op_div_q    <= is_div;
        exc_force_q <= div_zero;
        rd_q        <= in_ir[RD_HI:RD_LO];
      end else if (state == BUSY) begin
        count <= count + CW'(1);
      end
      if (in_done) result_q <= final_res;
    end
  end

  assign in_done      = (state == DONE);
  assign result_valid = in_done && !flush;
  assign exception    = result_valid && final_exc;
  assign result       = in_done ? final_res : result_q;
  assign result_rd    = rd_q;
  // reset also masks the combinational start path so stall reads 0 throughout reset
  assign stall        = (start || (state == BUSY)) && !reset;

endmodule
